bram_arbiter: RTL

Shares one single-port synchronous block RAM (`mybram`-style: registered read, one-cycle read latency, write on `we`) between two requesters, A and B, such as a serial-port engine and a host-side loader. Grants one RAM access per cycle, keeps ownership with the current requester for bounded bursts and switches round-robin when the burst limit is reached. Returns read data to the issuing requester with a fixed latency.

---
 rtl/bram_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Purpose  : Shares one single-port synchronous block RAM (one-cycle
//            registered read) between two requesters, A and B. One access is
//            granted per cycle. The current owner keeps the RAM for bursts of
//            up to MAXBURST grants while the other side waits, after which
//            ownership passes round-robin. Read data is returned on a shared
//            registered bus with a per-requester valid pulse two cycles after
//            the grant.
// Ports    : clk, rst                     clock, async active-high reset
//            a_req_i/a_we_i/a_addr_i/a_wdata_i  requester A command
//            a_gnt_o (comb), a_rvalid_o    requester A accept / read valid
//            b_*                           same for requester B
//            rdata_o                       read data (shared, registered)
//            ram_addr_o/ram_din_o/ram_we_o to RAM; ram_dout_i from RAM
// Revision : 1.0 - initial release
// ============================================================================
module bram_arbiter #(
  parameter int LOGSIZE  = 5,
  parameter int WIDTH    = 16,
  parameter int MAXBURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req_i,
  input  logic               a_we_i,
  input  logic [LOGSIZE-1:0] a_addr_i,
  input  logic [WIDTH-1:0]   a_wdata_i,
  output logic               a_gnt_o,
  output logic               a_rvalid_o,
  input  logic               b_req_i,
  input  logic               b_we_i,
  input  logic [LOGSIZE-1:0] b_addr_i,
  input  logic [WIDTH-1:0]   b_wdata_i,
  output logic               b_gnt_o,
  output logic               b_rvalid_o,
  output logic [WIDTH-1:0]   rdata_o,
  output logic [LOGSIZE-1:0] ram_addr_o,
  output logic [WIDTH-1:0]   ram_din_o,
  output logic               ram_we_o,
  input  logic [WIDTH-1:0]   ram_dout_i
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] C_MAXCNT = CW'(MAXBURST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN_A = 2'd1,
    S_OWN_B = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_b_q, last_b_d;   // 1: B was the last owner
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LOGSIZE-1:0] addr_hold_q;
  logic [WIDTH-1:0]   din_hold_q;
  logic               tag_v_q;              // read issued last cycle
  logic               tag_b_q;              // ... and it belonged to B
  logic [WIDTH-1:0]   rdata_q;
  logic               a_rvalid_q, b_rvalid_q;

  logic gnt_a, gnt_b, cnt_full;
  logic [CW-1:0] cnt_inc;

  assign cnt_full = (cnt_q == C_MAXCNT);
  assign cnt_inc  = cnt_full ? cnt_q : cnt_q + 1'b1;

  // Grant decision: combinational from requests and registered ownership.
  // Reset masks the grants so nothing reaches the RAM while rst is high.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_req_i && b_req_i) begin
          gnt_a = last_b_q;
          gnt_b = ~last_b_q;
        end else begin
          gnt_a = a_req_i;
          gnt_b = b_req_i;
        end
      end
      S_OWN_A: begin
        if (a_req_i && !(b_req_i && cnt_full)) gnt_a = 1'b1;
        else if (b_req_i)                      gnt_b = 1'b1;
      end
      S_OWN_B: begin
        if (b_req_i && !(a_req_i && cnt_full)) gnt_b = 1'b1;
        else if (a_req_i)                      gnt_a = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    if (gnt_a) begin
      state_d  = S_OWN_A;
      last_b_d = 1'b0;
      cnt_d    = (state_q == S_OWN_A) ? cnt_inc : CW'(1);
    end else if (gnt_b) begin
      state_d  = S_OWN_B;
      last_b_d = 1'b1;
      cnt_d    = (state_q == S_OWN_B) ? cnt_inc : CW'(1);
    end else begin
      state_d  = S_IDLE;
      cnt_d    = '0;
    end
  end

  // RAM mux; when idle the address/data lines keep the last granted values.
  assign ram_addr_o = gnt_a ? a_addr_i  : (gnt_b ? b_addr_i  : addr_hold_q);
  assign ram_din_o  = gnt_a ? a_wdata_i : (gnt_b ? b_wdata_i : din_hold_q);
  assign ram_we_o   = (gnt_a & a_we_i) | (gnt_b & b_we_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_b_q    <= 1'b1;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      din_hold_q  <= '0;
      tag_v_q     <= 1'b0;
      tag_b_q     <= 1'b0;
      rdata_q     <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      if (gnt_a || gnt_b) begin
        addr_hold_q <= ram_addr_o;
        din_hold_q  <= ram_din_o;
      end
      // Stage 1: remember who issued a read; the RAM registers its output
      // at this same edge, so the data is captured one edge later.
      tag_v_q    <= (gnt_a & ~a_we_i) | (gnt_b & ~b_we_i);
      tag_b_q    <= gnt_b;
      if (tag_v_q) rdata_q <= ram_dout_i;
      a_rvalid_q <= tag_v_q & ~tag_b_q;
      b_rvalid_q <= tag_v_q & tag_b_q;
    end
  end

  assign a_gnt_o    = gnt_a;
  assign b_gnt_o    = gnt_b;
  assign a_rvalid_o = a_rvalid_q;
  assign b_rvalid_o = b_rvalid_q;
  assign rdata_o    = rdata_q;

endmodule
`default_nettype wire
